// File: rtl/id_token_tracker.sv
// Identifier token tracker: watches the recognizer's char/match stream, counts
// completed tokens, tracks the longest one and queues token lengths for a host.
module id_token_tracker #(
  parameter int unsigned COUNT_W        = 16,
  parameter int unsigned LEN_FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         char,
  input  logic               match,
  input  logic               rd_en,
  output logic               tok_pulse,
  output logic [COUNT_W-1:0] tok_count,
  output logic [7:0]         max_len,
  output logic [7:0]         len_data,
  output logic               len_valid,
  output logic               overflow
);

  localparam int unsigned AW = (LEN_FIFO_DEPTH > 1) ? $clog2(LEN_FIFO_DEPTH) : 1;

  logic [7:0]  run_len;
  logic [7:0]  mem [LEN_FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] occ;
  logic        is_alnum;
  logic        tok_end;
  logic        fifo_empty;
  logic        fifo_full;
  logic        do_pop;
  logic        do_push;

  // Character classification and FIFO handshake decode
  always_comb begin
    is_alnum   = ((char >= 8'h41) && (char <= 8'h5A)) ||
                 ((char >= 8'h61) && (char <= 8'h7A)) ||
                 ((char >= 8'h30) && (char <= 8'h39));
    tok_end    = match && !is_alnum;
    occ        = wr_ptr - rd_ptr;
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (occ == (AW+1)'(LEN_FIFO_DEPTH));
    do_pop     = rd_en && !fifo_empty;
    // A full FIFO still accepts a push when the head leaves on the same edge
    do_push    = tok_end && (!fifo_full || do_pop);
  end

  // Run length, token statistics and FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      run_len   <= 8'd0;
      tok_pulse <= 1'b0;
      tok_count <= '0;
      max_len   <= 8'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
    end else begin
      if (is_alnum) begin
        if (run_len != 8'hFF) run_len <= run_len + 8'd1;
      end else begin
        run_len <= 8'd0;
      end
      tok_pulse <= tok_end;
      if (tok_end) begin
        if (tok_count != {COUNT_W{1'b1}}) tok_count <= tok_count + COUNT_W'(1);
        if (run_len > max_len) max_len <= run_len;
        if (!do_push) overflow <= 1'b1;
      end
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Length storage; contents are only visible through the pointers
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= run_len;
  end

  assign len_valid = !fifo_empty;
  assign len_data  = fifo_empty ? 8'd0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_id_token_tracker.sv
// Self-checking bench for id_token_tracker with a length scoreboard queue.
module tb_id_token_tracker;

  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    char_i;
  logic          match_i;
  logic          rd_i;
  logic          tok_pulse;
  logic [CW-1:0] tok_count;
  logic [7:0]    max_len;
  logic [7:0]    len_data;
  logic          len_valid;
  logic          overflow;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int m_run, m_cnt, m_max;
  bit m_ovf;
  int m_q[$];
  int exp_pulses, obs_pulses;

  id_token_tracker #(.COUNT_W(CW), .LEN_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .char(char_i), .match(match_i), .rd_en(rd_i),
    .tok_pulse(tok_pulse), .tok_count(tok_count), .max_len(max_len),
    .len_data(len_data), .len_valid(len_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic bit alnum(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A) ||
           (c >= 8'h30 && c <= 8'h39);
  endfunction

  // Drive one cycle; the model predicts the post-edge state
  task automatic step(input logic [7:0] c, input bit m, input bit rd);
    bit an, e;
    an = alnum(c);
    e  = m && !an;
    char_i = c; match_i = m; rd_i = rd;
    if (rd && m_q.size() > 0) void'(m_q.pop_front());
    if (e) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_run);
      else m_ovf = 1'b1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
      if (m_run > m_max) m_max = m_run;
      exp_pulses++;
    end
    m_run = an ? ((m_run < 255) ? m_run + 1 : 255) : 0;
    @(posedge clk);
    @(negedge clk);
    if (tok_pulse === 1'b1) obs_pulses++;
  endtask

  // Match rises on alnum once a run exists; at a separator it follows m_sep
  task automatic send_str(input string s, input bit m_sep, input bit rd);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c;
      c = s[i];
      step(c, alnum(c) ? (m_run >= 1) : m_sep, rd);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; char_i = 8'h00; match_i = 1'b0; rd_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_run = 0; m_cnt = 0; m_max = 0; m_ovf = 0; m_q.delete();
    exp_pulses = 0; obs_pulses = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (tok_count !== '0 || tok_pulse !== 1'b0 || max_len !== 8'd0) $display("FAIL reset_regs count=%0d pulse=%0b max=%0d want 0/0/0", tok_count, tok_pulse, max_len); else n_pass++;
    n_checks++; if (len_valid !== 1'b0 || len_data !== 8'd0 || overflow !== 1'b0) $display("FAIL reset_fifo valid=%0b data=%0d ovf=%0b want 0/0/0", len_valid, len_data, overflow); else n_pass++;
    step(8'h00, 1'b0, 1'b1);
    n_checks++; if (len_valid !== 1'b0) $display("FAIL pop_empty valid=%0b want 0", len_valid); else n_pass++;
  endtask

  task automatic test_single_token();
    do_reset();
    send_str("ab12", 1'b1, 1'b0);
    n_checks++; if (tok_pulse !== 1'b0) $display("FAIL t1_pulse_early got %0b want 0", tok_pulse); else n_pass++;
    // separator with rd_en while empty: push only, no bypass
    send_str(" ", 1'b1, 1'b1);
    n_checks++; if (tok_pulse !== 1'b1) $display("FAIL t1_pulse got %0b want 1", tok_pulse); else n_pass++;
    n_checks++; if (tok_count !== 4'd1 || max_len !== 8'd4) $display("FAIL t1_stats count=%0d max=%0d want 1/4", tok_count, max_len); else n_pass++;
    n_checks++; if (len_valid !== 1'b1 || len_data !== 8'(m_q[0]) || len_data !== 8'd4) $display("FAIL t1_fifo valid=%0b data=%0d want 1/4", len_valid, len_data); else n_pass++;
    step(8'h2E, 1'b0, 1'b0);
    n_checks++; if (tok_pulse !== 1'b0) $display("FAIL t1_pulse_width got %0b want 0", tok_pulse); else n_pass++;
  endtask

  task automatic test_no_match();
    do_reset();
    send_str("abc ", 1'b0, 1'b0);
    send_str("9x ", 1'b0, 1'b0);
    n_checks++; if (tok_count !== '0 || len_valid !== 1'b0) $display("FAIL nomatch count=%0d valid=%0b want 0/0", tok_count, len_valid); else n_pass++;
    n_checks++; if (obs_pulses !== 0 || exp_pulses !== 0) $display("FAIL nomatch_pulses got %0d want 0", obs_pulses); else n_pass++;
  endtask

  task automatic test_overflow();
    int exp3[4] = '{2, 4, 4, 2};
    do_reset();
    send_str("a1 bb22 c333 x4 y5 ", 1'b1, 1'b0);
    n_checks++; if (tok_count !== 4'd5 || max_len !== 8'd4) $display("FAIL ovf_stats count=%0d max=%0d want 5/4", tok_count, max_len); else n_pass++;
    n_checks++; if (overflow !== 1'b1 || m_ovf !== 1'b1) $display("FAIL ovf_flag got %0b want 1", overflow); else n_pass++;
    n_checks++; if (obs_pulses !== exp_pulses) $display("FAIL ovf_pulses got %0d want %0d", obs_pulses, exp_pulses); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (len_valid !== 1'b1 || len_data !== 8'(exp3[i]) || len_data !== 8'(m_q[0])) $display("FAIL ovf_pop%0d valid=%0b data=%0d want 1/%0d", i, len_valid, len_data, exp3[i]); else n_pass++;
      step(8'h00, 1'b0, 1'b1);
    end
    n_checks++; if (len_valid !== 1'b0 || len_data !== 8'd0 || overflow !== 1'b1) $display("FAIL ovf_drained valid=%0b data=%0d ovf=%0b want 0/0/1", len_valid, len_data, overflow); else n_pass++;
  endtask

  task automatic test_push_pop_full();
    int exp4[4] = '{3, 4, 5, 3};
    do_reset();
    send_str("a1 bb2 ccc3 dddd4 xyz", 1'b1, 1'b0);
    send_str(" ", 1'b1, 1'b1);
    n_checks++; if (overflow !== 1'b0 || tok_count !== 4'd5) $display("FAIL full_pp ovf=%0b count=%0d want 0/5", overflow, tok_count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (len_valid !== 1'b1 || len_data !== 8'(exp4[i]) || len_data !== 8'(m_q[0])) $display("FAIL full_pop%0d valid=%0b data=%0d want 1/%0d", i, len_valid, len_data, exp4[i]); else n_pass++;
      step(8'h00, 1'b0, 1'b1);
    end
    n_checks++; if (len_valid !== 1'b0) $display("FAIL full_occ valid=%0b want 0", len_valid); else n_pass++;
  endtask

  task automatic test_saturate_len();
    do_reset();
    for (int i = 0; i < 300; i++) step(8'h61, (i > 0), 1'b0);
    send_str("1 ", 1'b1, 1'b0);
    n_checks++; if (len_data !== 8'd255 || len_data !== 8'(m_q[0]) || max_len !== 8'd255) $display("FAIL sat_len data=%0d max=%0d want 255/255", len_data, max_len); else n_pass++;
  endtask

  task automatic test_reset_mid_token();
    do_reset();
    send_str("ab1", 1'b1, 1'b0);
    do_reset();
    send_str("2 ", 1'b0, 1'b0);
    n_checks++; if (tok_count !== '0 || len_valid !== 1'b0 || obs_pulses !== 0) $display("FAIL midreset count=%0d valid=%0b pulses=%0d want 0/0/0", tok_count, len_valid, obs_pulses); else n_pass++;
  endtask

  task automatic test_count_saturate();
    do_reset();
    for (int i = 0; i < 15; i++) send_str("q7 ", 1'b1, 1'b1);
    n_checks++; if (tok_count !== 4'd15 || tok_count !== CW'(m_cnt)) $display("FAIL cnt15 got %0d want 15", tok_count); else n_pass++;
    send_str("zz ", 1'b1, 1'b1);
    n_checks++; if (tok_count !== 4'd15 || tok_pulse !== 1'b1) $display("FAIL cnt_hold count=%0d pulse=%0b want 15/1", tok_count, tok_pulse); else n_pass++;
    n_checks++; if (overflow !== 1'b0 || obs_pulses !== 16) $display("FAIL cnt_misc ovf=%0b pulses=%0d want 0/16", overflow, obs_pulses); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; char_i = 8'h00; match_i = 1'b0; rd_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_token();
    test_no_match();
    test_overflow();
    test_push_pop_full();
    test_saturate_len();
    test_reset_mid_token();
    test_count_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
